// File: rtl/sudoku_pkg.sv
// rtl/sudoku_pkg.sv - shared board geometry, loader state encoding and LFSR taps
package sudoku_pkg;

    localparam int CELLS             = 81;
    localparam int CELL_W            = 5;
    localparam int BOARD_W           = 405;
    localparam int CELL_REVEALED_BIT = 4;
    localparam int CELL_VALUE_MSB    = 3;
    localparam int IDX_W             = 7;

    localparam logic [IDX_W-1:0] LAST_IDX  = 7'd80;
    localparam logic [15:0]      LFSR_TAPS = 16'hB400;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } load_state_e;

    // A legal sudoku cell value is 1..9.
    function automatic logic cell_value_bad(input logic [CELL_VALUE_MSB:0] v);
        return (v == 4'd0) || (v > 4'd9);
    endfunction

endpackage

// File: rtl/lfsr16.sv
// rtl/lfsr16.sv - free-running 16-bit Galois LFSR
//
// Ports:
//   clk   - system clock
//   reset - asynchronous active-low reset, loads SEED
//   q     - current LFSR state, advances every clock
module lfsr16
    import sudoku_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    output logic [15:0] q
);

    // Galois form: shift right and fold the taps in when a one falls out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= SEED;
        end else begin
            q <= {1'b0, q[15:1]} ^ (q[0] ? LFSR_TAPS : 16'h0000);
        end
    end

endmodule

// File: rtl/map_loader.sv
// rtl/map_loader.sv - loads one puzzle map from the map ROM into the game board
//
// Ports:
//   clk, reset                 - clock, asynchronous active-low reset
//   start                      - load request pulse, only honoured in IDLE
//   difficulty                 - 0 easy, 1 hard (extra cells hidden); captured with start
//   map_override_en/_override  - force the map index instead of the LFSR pick
//   rom_en, rom_addr, rom_data - ROM read port, data valid one cycle after rom_en
//   board                      - 81 cells x 5 bits, cell k at [5k +: 5]
//   busy, done                 - busy while loading; done pulses when board is complete
//   map_id                     - map chosen at the last accepted start
//   revealed_count             - revealed cells in the loaded board
//   bad_cell                   - sticky flag: a loaded value was 0 or above 9
module map_loader
    import sudoku_pkg::*;
#(
    parameter int          MAP_BITS  = 3,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      difficulty,
    input  logic                      map_override_en,
    input  logic [MAP_BITS-1:0]       map_override,
    output logic                      rom_en,
    output logic [MAP_BITS+IDX_W-1:0] rom_addr,
    input  logic [CELL_W-1:0]         rom_data,
    output logic [BOARD_W-1:0]        board,
    output logic                      busy,
    output logic                      done,
    output logic [MAP_BITS-1:0]       map_id,
    output logic [IDX_W-1:0]          revealed_count,
    output logic                      bad_cell
);

    load_state_e         state;
    logic                diff_q;
    logic                wr_valid;
    logic [IDX_W-1:0]    wr_idx;
    logic [15:0]         lfsr;
    logic [MAP_BITS-1:0] map_sel;
    logic                hide;
    logic [CELL_W-1:0]   wr_cell;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .q     (lfsr)
    );

    assign map_sel = map_override_en ? map_override : lfsr[MAP_BITS-1:0];

    // On hard, roughly one in four revealed cells is additionally hidden.
    // Only the revealed flag is touched; the solution value is kept intact.
    assign hide    = diff_q & (lfsr[1:0] == 2'b00);
    assign wr_cell = {rom_data[CELL_REVEALED_BIT] & ~hide, rom_data[CELL_VALUE_MSB:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            diff_q         <= 1'b0;
            wr_valid       <= 1'b0;
            wr_idx         <= '0;
            rom_en         <= 1'b0;
            rom_addr       <= '0;
            board          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            map_id         <= '0;
            revealed_count <= '0;
            bad_cell       <= 1'b0;
        end else begin
            // Read data lags the address by one cycle, so the write side
            // follows the issued index through a one-stage pipeline.
            wr_valid <= rom_en;
            wr_idx   <= rom_addr[IDX_W-1:0];
            done     <= 1'b0;

            if (wr_valid) begin
                board[CELL_W*int'(wr_idx) +: CELL_W] <= wr_cell;
                revealed_count <= revealed_count + IDX_W'(wr_cell[CELL_REVEALED_BIT]);
                if (cell_value_bad(rom_data[CELL_VALUE_MSB:0])) begin
                    bad_cell <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        diff_q         <= difficulty;
                        map_id         <= map_sel;
                        board          <= '0;
                        revealed_count <= '0;
                        bad_cell       <= 1'b0;
                        rom_en         <= 1'b1;
                        rom_addr       <= {map_sel, {IDX_W{1'b0}}};
                        busy           <= 1'b1;
                        state          <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (rom_addr[IDX_W-1:0] == LAST_IDX) begin
                        rom_en <= 1'b0;
                        state  <= ST_DRAIN;
                    end else begin
                        rom_addr[IDX_W-1:0] <= rom_addr[IDX_W-1:0] + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Last cell is written this cycle by the pipeline above.
                    done  <= 1'b1;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_map_loader.sv
// tb/tb_map_loader.sv - directed self-checking bench for map_loader
module tb_map_loader;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         difficulty = 1'b0;
    logic         map_override_en = 1'b0;
    logic [2:0]   map_override = 3'd0;
    logic         rom_en;
    logic [9:0]   rom_addr;
    logic [4:0]   rom_data;
    logic [404:0] board;
    logic         busy;
    logic         done;
    logic [2:0]   map_id;
    logic [6:0]   revealed_count;
    logic         bad_cell;

    int           total = 0;
    int           bad = 0;
    logic [1:0]   rom_mode = 2'd0;
    logic [15:0]  ref_lfsr;

    int           done_cnt;
    int           done_at;
    int           seq_err;
    int           exp_rc;
    int           hidden;
    logic [2:0]   exp_map;
    logic [404:0] exp_board;
    logic [4:0]   cell_tmp;

    always #5 clk = ~clk;

    map_loader #(
        .MAP_BITS  (3),
        .LFSR_SEED (16'hACE1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .difficulty      (difficulty),
        .map_override_en (map_override_en),
        .map_override    (map_override),
        .rom_en          (rom_en),
        .rom_addr        (rom_addr),
        .rom_data        (rom_data),
        .board           (board),
        .busy            (busy),
        .done            (done),
        .map_id          (map_id),
        .revealed_count  (revealed_count),
        .bad_cell        (bad_cell)
    );

    function automatic logic [4:0] rom_fn(input logic [2:0] m, input logic [6:0] k,
                                          input logic [1:0] mode);
        logic [3:0] v;
        logic       r;
        if (mode == 2'd2 && k == 7'd17) return 5'b1_1010;
        if (m == 3'd2) begin
            v = 4'(k % 9) + 4'd1;
            r = (mode == 2'd1) ? 1'b1 : ~k[0];
        end else begin
            v = 4'd9 - 4'(k % 9);
            r = k[0];
        end
        return {r, v};
    endfunction

    // Reference LFSR, seed ACE1, Galois taps B400.
    always @(posedge clk or negedge reset) begin
        if (!reset) ref_lfsr <= 16'hACE1;
        else        ref_lfsr <= ref_lfsr[0] ? ((ref_lfsr >> 1) ^ 16'hB400) : (ref_lfsr >> 1);
    end

    // Synchronous ROM: data one cycle after rom_en.
    always @(posedge clk) begin
        rom_data <= rom_en ? rom_fn(rom_addr[9:7], rom_addr[6:0], rom_mode) : 5'h00;
    end

    task automatic chk(input string tag, input logic [404:0] got, input logic [404:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issues a start (sampled at edge T) and observes cycles T+1..T+84.
    // pa/pb: extra start pulses during the load; rst_at: assert reset at that cycle.
    task automatic do_load(input logic diff, input logic ov_en, input logic [2:0] ov,
                           input int pa, input int pb, input int rst_at);
        int k;
        logic h;
        @(negedge clk);
        difficulty = diff;
        map_override_en = ov_en;
        map_override = ov;
        start = 1'b1;
        exp_map = ov_en ? ov : ref_lfsr[2:0];
        exp_board = '0;
        exp_rc = 0;
        hidden = 0;
        done_cnt = 0;
        done_at = 0;
        seq_err = 0;
        for (int c = 1; c <= 84; c++) begin
            @(negedge clk);
            start = (c == pa) || (c == pb);
            map_override = ((c == pa) || (c == pb)) ? ~ov : ov;
            if (done) begin
                done_cnt++;
                done_at = c;
            end
            if (rst_at == 0) begin
                if (busy !== (c <= 83)) seq_err++;
                if (rom_en !== (c <= 81)) seq_err++;
                if (c <= 81 && rom_addr !== {exp_map, 7'(c - 1)}) seq_err++;
                if (c >= 2 && c <= 82) begin
                    k = c - 2;
                    cell_tmp = rom_fn(exp_map, 7'(k), rom_mode);
                    h = diff && (ref_lfsr[1:0] == 2'b00);
                    if (h && cell_tmp[4]) hidden++;
                    cell_tmp[4] = cell_tmp[4] & ~h;
                    exp_board[5*k +: 5] = cell_tmp;
                    exp_rc += int'(cell_tmp[4]);
                end
            end else begin
                if (c == rst_at + 1) begin
                    chk("rst_mid_board", board, 0);
                    chk("rst_mid_busy", busy, 0);
                    chk("rst_mid_rom_en", rom_en, 0);
                    chk("rst_mid_done", done, 0);
                    chk("rst_mid_rc", revealed_count, 0);
                end
                if (c == rst_at) reset = 1'b0;
                if (c == rst_at + 2) reset = 1'b1;
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_board", board, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rom_en", rom_en, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_map_id", map_id, 0);
        chk("rst_rc", revealed_count, 0);
        chk("rst_bad_cell", bad_cell, 0);
        reset = 1'b1;

        // Easy, map 2, alternating revealed cells.
        rom_mode = 2'd0;
        do_load(1'b0, 1'b1, 3'd2, 0, 0, 0);
        chk("t1_done_cnt", done_cnt, 1);
        chk("t1_done_at", done_at, 83);
        chk("t1_seq", seq_err, 0);
        chk("t1_board", board, exp_board);
        chk("t1_rc", revealed_count, 41);
        chk("t1_bad_cell", bad_cell, 0);
        chk("t1_map_id", map_id, 2);

        // Hard, map 2, all revealed: LFSR-driven extra hiding.
        rom_mode = 2'd1;
        do_load(1'b1, 1'b1, 3'd2, 0, 0, 0);
        chk("t2_done_at", done_at, 83);
        chk("t2_board", board, exp_board);
        chk("t2_rc", revealed_count, 81 - hidden);
        chk("t2_seq", seq_err, 0);

        // Starts during a load are ignored; map_override changes ignored.
        rom_mode = 2'd0;
        do_load(1'b0, 1'b1, 3'd5, 10, 50, 0);
        chk("t3_done_cnt", done_cnt, 1);
        chk("t3_done_at", done_at, 83);
        chk("t3_map_id", map_id, 5);
        chk("t3_seq", seq_err, 0);
        chk("t3_board", board, exp_board);
        chk("t3_rc", revealed_count, 40);
        // Start at T+84 launches a fresh load.
        do_load(1'b0, 1'b1, 3'd3, 0, 0, 0);
        chk("t3b_seq", seq_err, 0);
        chk("t3b_done_at", done_at, 83);
        chk("t3b_map_id", map_id, 3);

        // Reset in the middle of a load.
        do_load(1'b0, 1'b1, 3'd1, 0, 0, 40);
        chk("t4_no_done", done_cnt, 0);
        chk("t4_board", board, 0);
        chk("t4_busy", busy, 0);
        chk("t4_map_id", map_id, 0);
        do_load(1'b0, 1'b1, 3'd2, 0, 0, 0);
        chk("t4b_done_at", done_at, 83);
        chk("t4b_seq", seq_err, 0);
        chk("t4b_board", board, exp_board);
        chk("t4b_rc", revealed_count, 41);

        // Out-of-range value at cell 17.
        rom_mode = 2'd2;
        do_load(1'b0, 1'b1, 3'd2, 0, 0, 0);
        chk("t5_bad_cell", bad_cell, 1);
        chk("t5_cell17", board[85 +: 5], 5'b1_1010);
        chk("t5_board", board, exp_board);
        chk("t5_rc", revealed_count, 42);
        rom_mode = 2'd0;
        do_load(1'b0, 1'b1, 3'd2, 0, 0, 0);
        chk("t5b_bad_cell", bad_cell, 0);
        chk("t5b_board", board, exp_board);

        // LFSR map pick, start five cycles after reset release.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(negedge clk);
        do_load(1'b0, 1'b0, 3'd0, 0, 0, 0);
        chk("t6_map_id", map_id, exp_map);
        chk("t6_seq", seq_err, 0);
        chk("t6_done_at", done_at, 83);
        chk("t6_board", board, exp_board);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/map_loader.md
Name: map_loader

Overview:
- Sequences loading of a puzzle from the external map ROM into the 405-bit game board before play starts.
- Picks a map by free-running LFSR, or by override for level-select and test.
- Applies difficulty-dependent extra hiding of cells.
- Sits between the difficulty-select stage of the game FSM and the board register/ROM; the game FSM pulses start and waits for done.

Parameters:
- MAP_BITS, 3, log2 of number of maps in ROM (NUM_MAPS = 2^MAP_BITS).
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- start  in  1  load request pulse, sampled only in IDLE
- difficulty  in  1  0 = easy, 1 = hard; captured with start
- map_override_en  in  1  1 = use map_override instead of LFSR
- map_override  in  MAP_BITS  forced map index
- rom_en  out  1  ROM read enable
- rom_addr  out  MAP_BITS+7  {map_id, cell index 0..80}
- rom_data  in  5  ROM cell: [4] revealed, [3:0] value; valid one cycle after rom_en
- board  out  405  cell k at [5k +: 5], row-major (k = x + 9y)
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when board is complete
- map_id  out  MAP_BITS  map captured at last start
- revealed_count  out  7  revealed cells in loaded board; valid from done
- bad_cell  out  1  sticky: some loaded value was 0 or >9

Behaviour:
- Reset (reset = 0, async): state = IDLE; board = 0; busy, done, rom_en, bad_cell = 0; rom_addr, map_id, revealed_count = 0; LFSR = LFSR_SEED.
- LFSR: 16-bit Galois, taps 16'hB400. Advances every clock in every state, so map choice depends on start timing.
- States: IDLE -> LOAD -> DRAIN -> DONE -> IDLE.
- IDLE, start = 1 at edge T:
  - Capture diff_q = difficulty.
  - Capture map_id = map_override_en ? map_override : lfsr[MAP_BITS-1:0].
  - Clear board, revealed_count and bad_cell; idx = 0; go to LOAD.
- LOAD (cycles T+1 .. T+81):
  - rom_en = 1, rom_addr = {map_id, idx}; idx increments each cycle.
  - After idx = 80 is issued, go to DRAIN; rom_en = 0 outside LOAD.
- Write path: rom_data for idx k arrives in cycle T+2+k and is written to board[5k +: 5] at the end of that cycle. The 1-cycle-delayed idx/valid pipeline covers the last write in DRAIN (cycle T+82).
- Written cell = {rom_data[4] & ~hide, rom_data[3:0]}.
  - hide = diff_q & (lfsr[1:0] == 2'b00), sampled in the write cycle.
  - The value nibble is never altered.
- On each write:
  - revealed_count += written revealed bit. Saturation is not needed; max is 81.
  - bad_cell sets if rom_data[3:0] == 0 or > 9; the data is still written.
- DONE (cycle T+83): done = 1 for exactly one cycle; busy still 1. Next cycle is IDLE with busy = 0.
- Total: 83 cycles from start edge to done cycle.
- board holds its value in IDLE until the next accepted start. During LOAD it is partially filled; consumers must wait for done.
- start while busy: ignored, no queueing.
- start held high: one load per IDLE entry; a new load begins the cycle after return to IDLE.
- reset mid-load: immediate return to IDLE with all reset values; no done.
- map_override_en is sampled only at start.

Decomposition:
- Shared package sudoku_pkg:
  - CELLS = 81, CELL_W = 5, BOARD_W = 405.
  - CELL_REVEALED_BIT = 4, CELL_VALUE_MSB = 3.
  - Loader state encoding.
  - LFSR_TAPS = 16'hB400.
- One sub-module, lfsr16: free-running Galois LFSR with seed parameter, output q[15:0]. Reusable by later randomised features.

Test Plan:
- Override map 2, easy: ROM model with map 2 = cells {1,value=(k mod 9)+1} for even k and {0,value} for odd k.
  - busy rises at T+1, done at T+83.
  - board[5k +: 5] matches ROM exactly.
  - revealed_count = 41, bad_cell = 0.
- Hard, override map 2, all-revealed ROM map: hidden cells are exactly those where the reference-model LFSR[1:0] == 0 at each write cycle; revealed_count = 81 minus that count; value nibbles unchanged.
- Start pulsed at T+10 and T+50 during a load: single done at T+83; map_id unchanged. A start at T+84 launches a new load.
- Reset asserted at T+40: board = 0, busy = 0, no done pulse; a new start completes normally in 83 cycles.
- ROM cell 17 = 5'b1_1010 (value 10): bad_cell = 1 at done; cell written as 5'b1_1010. The next load with clean data clears bad_cell.
- map_override_en = 0, start 5 cycles after reset release: map_id equals reference LFSR (seed ACE1) bits [2:0] at that edge; rom_addr[9:7] = map_id throughout LOAD.
